// File: rtl/avmm_cfg_pkg.sv
// avmm_cfg_pkg: shared types and constants for the Avalon-MM config master
package avmm_cfg_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} avmm_state_t;
  localparam int ERR_W = 8;
  localparam int DEF_TIMEOUT = 255;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant that starts searching one past the last winner
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          adv,
  input  logic [N-1:0]  req,
  output logic          grant_valid,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] last;
  logic [IW-1:0] c;
  // scan from farthest to nearest so the channel closest after last wins
  always_comb begin
    grant_valid = 1'b0;
    grant = '0;
    grant_idx = '0;
    c = '0;
    for (int i = N; i >= 1; i--) begin
      c = IW'((int'(last) + i) % N);
      if (req[c]) begin
        grant_valid = 1'b1;
        grant = '0;
        grant[c] = 1'b1;
        grant_idx = c;
      end
    end
  end
  // remember the winner each time a grant is taken
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) last <= IW'(N - 1);
    else if (adv && grant_valid) last <= grant_idx;
endmodule

// File: rtl/avmm_cfg_master.sv
// avmm_cfg_master: serialises requester register accesses onto one Avalon-MM slave with a watchdog
module avmm_cfg_master
  import avmm_cfg_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 2,
  parameter int USE_RDV = 0,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     CLK_I,
  input  logic                     RST_I,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_adr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  output logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH-1:0]        ch_err,
  output logic [DATA_W-1:0]        rd_data,
  output logic [ERR_W-1:0]         err_cnt,
  output logic [ADDR_W-1:0]        ADR_O,
  output logic [DATA_W-1:0]        DAT_O,
  output logic                     RD,
  output logic                     WR,
  input  logic [DATA_W-1:0]        DAT_I,
  input  logic                     BUSY,
  input  logic                     RDV_I
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  avmm_state_t state;
  logic [NUM_CH-1:0] sel;
  logic [NUM_CH-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic gnt_valid;
  logic [15:0] wd;
  logic expire;
  rr_arbiter #(.N(NUM_CH)) u_arb (
    .CLK_I(CLK_I),
    .RST_I(RST_I),
    .adv(state == IDLE),
    .req(ch_req),
    .grant_valid(gnt_valid),
    .grant(gnt),
    .grant_idx(gnt_idx)
  );
  // a completion or an abort in the same cycle takes priority over the watchdog; >= keeps RWAIT from slipping past the limit
  assign expire = wd >= 16'(TIMEOUT) && (state == ISSUE ? BUSY && |(ch_req & sel) : state == RWAIT && !RDV_I);
  // command FSM with registered Avalon outputs, watchdog and result registers
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      state <= IDLE;
      sel <= '0;
      wd <= '0;
      ADR_O <= '0;
      DAT_O <= '0;
      RD <= 1'b0;
      WR <= 1'b0;
      ch_done <= '0;
      ch_err <= '0;
      rd_data <= '0;
      err_cnt <= '0;
    end else begin
      ch_done <= '0;
      ch_err <= '0;
      if (state != IDLE) wd <= wd + 16'd1;
      if (expire) begin
        state <= IDLE;
        RD <= 1'b0;
        WR <= 1'b0;
        ch_done <= sel;
        ch_err <= sel;
        rd_data <= '0;
        if (~&err_cnt) err_cnt <= err_cnt + ERR_W'(1);
      end else case (state)
        IDLE: if (gnt_valid) begin
          state <= ISSUE;
          sel <= gnt;
          wd <= '0;
          ADR_O <= ch_adr[gnt_idx*ADDR_W +: ADDR_W];
          DAT_O <= ch_wdata[gnt_idx*DATA_W +: DATA_W];
          RD <= !ch_we[gnt_idx];
          WR <= ch_we[gnt_idx];
        end
        ISSUE: if (!BUSY) begin
          RD <= 1'b0;
          WR <= 1'b0;
          if (WR || USE_RDV == 0) begin
            state <= IDLE;
            ch_done <= sel;
            if (RD) rd_data <= DAT_I;
          end else state <= RWAIT;
        end else if (!(|(ch_req & sel))) begin
          state <= IDLE;
          RD <= 1'b0;
          WR <= 1'b0;
        end
        RWAIT: if (RDV_I) begin
          state <= IDLE;
          ch_done <= sel;
          rd_data <= DAT_I;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
